// File: rtl/rx_frame_decode_ctrl_if.sv
// Byte-in / coded-frame / decoded-message bus for the receive-side frame sequencer.
// The slave modport is the sequencer; the master modport is the surrounding environment.
interface rx_frame_decode_ctrl_if #(
    parameter int MSG_SIZE = 6,
    parameter int CODED_W  = 16
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [CODED_W-1:0]  dec_code;
    logic [MSG_SIZE-1:0] dec_msg;
    logic [MSG_SIZE-1:0] msg_data;
    logic                msg_valid;
    logic                msg_ready;

    modport master (
        output rx_data, rx_valid, dec_msg, msg_ready,
        input  dec_code, msg_data, msg_valid
    );

    modport slave (
        input  rx_data, rx_valid, dec_msg, msg_ready,
        output dec_code, msg_data, msg_valid
    );
endinterface

// File: rtl/rx_frame_decode_ctrl.sv
// Receive sequencer: packs UART bytes LSB-first into a coded frame, captures the decoder result
// into a valid/ready output buffer, with inter-byte timeout. Define RX_ERR_CNT_EN to build err_cnt.
module rx_frame_decode_ctrl #(
    parameter int STEP     = 0,
    parameter int MSG_SIZE = 6,
    parameter int TIMEOUT  = 10000
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_frame_decode_ctrl_if.slave bus,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 ovf,
    output logic [7:0]           err_cnt
);
    localparam int CODED_W = 2 * (MSG_SIZE + 2 * (2 * STEP + 1));
    localparam int NBYTES  = (CODED_W + 7) / 8;
    localparam int CW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CODED_W-1:0]  dec_code_q, dec_code_d;
    logic [MSG_SIZE-1:0] msg_data_q, msg_data_d;
    logic                msg_valid_q, msg_valid_d;
    logic                cap_stb_q, cap_stb_d;
    logic                busy_q, busy_d;
    logic                frame_err_q, frame_err_d;
    logic                ovf_q, ovf_d;
    logic                last_byte;
    logic                expire;

    always_comb begin
        last_byte = bus.rx_valid && (cnt_q == CNT_LAST);
        // An arriving byte always beats expiry in the same cycle.
        expire    = (TIMEOUT != 0) && (cnt_q != '0) && !bus.rx_valid && (timer_q == TMR_LAST);

        cnt_d = cnt_q;
        if (bus.rx_valid) begin
            cnt_d = last_byte ? '0 : cnt_q + CW'(1);
        end else if (expire) begin
            cnt_d = '0;
        end

        if (bus.rx_valid || (cnt_q == '0) || expire) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // Only bits of the byte lane being written change; lane bits past CODED_W are dropped.
        dec_code_d = dec_code_q;
        for (int i = 0; i < CODED_W; i++) begin
            if (bus.rx_valid && ((i / 8) == int'(cnt_q))) begin
                dec_code_d[i] = bus.rx_data[i % 8];
            end
        end

        cap_stb_d   = last_byte;
        msg_data_d  = msg_data_q;
        msg_valid_d = msg_valid_q;
        ovf_d       = 1'b0;
        if (cap_stb_q) begin
            if (!msg_valid_q || bus.msg_ready) begin
                msg_data_d  = bus.dec_msg;
                msg_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (msg_valid_q && bus.msg_ready) begin
            msg_valid_d = 1'b0;
        end

        busy_d      = (cnt_d != '0);
        frame_err_d = expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            timer_q     <= '0;
            dec_code_q  <= '0;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
            cap_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            dec_code_q  <= dec_code_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
            cap_stb_q   <= cap_stb_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef RX_ERR_CNT_EN
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts on the same edge that raises the pulse.
    always_comb begin
        err_cnt_d = sat_add8(err_cnt_q, {1'b0, frame_err_d} + {1'b0, ovf_d});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign bus.dec_code  = dec_code_q;
    assign bus.msg_data  = msg_data_q;
    assign bus.msg_valid = msg_valid_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;
    assign ovf           = ovf_q;
endmodule
